// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared types for the ALU sharing arbiter: word type, ALU opcode set,
// flag bundle, and the request/response records carried through the
// arbiter. ptr_w() gives the grant-pointer width for a requester count.
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    localparam int WORD_W  = 32;
    localparam int ALUOP_W = 4;
    localparam int FLAGS_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    // Codes 4'hA..4'hF are undefined; they are passed to the ALU untouched.
    typedef enum logic [ALUOP_W-1:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
    } alu_flags_t;

    typedef struct packed {
        aluop_t aluop;
        word_t  porta;
        word_t  portb;
    } alu_req_t;

    typedef struct packed {
        word_t      outport;
        alu_flags_t flags;
    } alu_rsp_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with an internal last-grant pointer.
//   CLK, nRST  : clock, async active-low reset
//   eligible   : per-requester request qualifier
//   grant      : one-hot (or zero) grant, combinational
//   any_grant  : some requester is granted this cycle
//   winner     : index of the granted requester (valid when any_grant)
// The pointer resets to N-1 so requester 0 has first priority, and moves to
// the winner only on cycles where a grant is issued.
// ---------------------------------------------------------------------------
module rr_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [N-1:0]          eligible,
    output logic [N-1:0]          grant,
    output logic                  any_grant,
    output logic [ptr_w(N)-1:0]   winner
);

    localparam int PTR_W = ptr_w(N);

    logic [PTR_W-1:0] last_grant_reg;

    // Cyclic search starting one past the last winner; first hit wins.
    always_comb begin : search
        logic [PTR_W-1:0] idx;
        idx       = '0;
        grant     = '0;
        any_grant = 1'b0;
        winner    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_W'((int'(last_grant_reg) + k) % N);
            if (!any_grant && eligible[idx]) begin
                any_grant = 1'b1;
                winner    = idx;
            end
        end
        if (any_grant) begin
            grant[winner] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant_reg <= PTR_W'(N - 1);
        end else if (any_grant) begin
            last_grant_reg <= winner;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between NREQ requesters. One operation is
// granted per cycle (round robin), the ALU result and flags are registered
// into the winner's response slot, and each slot is drained by its own
// valid/ready handshake.
//   CLK, nRST            : clock, async active-low reset
//   req_valid/req_ready  : request handshake (req_ready is the grant)
//   req_aluop/porta/portb: per-requester operation
//   rsp_valid/rsp_ready  : response handshake per slot
//   rsp_outport/rsp_flags: registered result {negative,zero,overflow}
//   alu_aluop/porta/portb: drive to the shared ALU (zero when idle)
//   alu_outport/alu_flags: result from the shared ALU
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0][ALUOP_W-1:0]  req_aluop,
    input  logic [NREQ-1:0][WORD_W-1:0]   req_porta,
    input  logic [NREQ-1:0][WORD_W-1:0]   req_portb,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [NREQ-1:0][WORD_W-1:0]   rsp_outport,
    output logic [NREQ-1:0][FLAGS_W-1:0]  rsp_flags,
    output logic [ALUOP_W-1:0]            alu_aluop,
    output logic [WORD_W-1:0]             alu_porta,
    output logic [WORD_W-1:0]             alu_portb,
    input  logic [WORD_W-1:0]             alu_outport,
    input  logic [FLAGS_W-1:0]            alu_flags
);

    localparam int PTR_W = ptr_w(NREQ);

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic             any_grant;
    logic [PTR_W-1:0] winner;
    alu_req_t         sel_req;
    alu_rsp_t         alu_rsp;

    // A full slot that is not draining this cycle blocks its requester.
    // Gating with nRST keeps grants and ALU drive at zero while in reset.
    assign eligible = {NREQ{nRST}} & req_valid & (~rsp_valid | rsp_ready);

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .CLK       (CLK),
        .nRST      (nRST),
        .eligible  (eligible),
        .grant     (grant),
        .any_grant (any_grant),
        .winner    (winner)
    );

    assign req_ready = grant;

    // Operand mux: winner's operation, or all zero when nothing is accepted.
    always_comb begin
        sel_req = '0;
        if (any_grant) begin
            sel_req.aluop = aluop_t'(req_aluop[winner]);
            sel_req.porta = req_porta[winner];
            sel_req.portb = req_portb[winner];
        end
    end

    assign alu_aluop = sel_req.aluop;
    assign alu_porta = sel_req.porta;
    assign alu_portb = sel_req.portb;

    assign alu_rsp.outport = alu_outport;
    assign alu_rsp.flags   = alu_flags_t'(alu_flags);

    // Response slots. A new accept takes priority over the drain so that a
    // slot emptied and refilled on the same edge stays valid with new data.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        logic     valid_reg;
        alu_rsp_t data_reg;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else if (grant[gi]) begin
                valid_reg <= 1'b1;
                data_reg  <= alu_rsp;
            end else if (rsp_ready[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign rsp_valid[gi]   = valid_reg;
        assign rsp_outport[gi] = data_reg.outport;
        assign rsp_flags[gi]   = data_reg.flags;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter (NREQ=2) with a behavioural ALU
// behind it. The stimulus pushes hand-computed results into per-requester
// queues when a grant is expected; an independent monitor pops and compares
// whenever a response slot is consumed.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    logic              clk;
    logic              nRST;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][3:0]   req_aluop;
    logic [1:0][31:0]  req_porta;
    logic [1:0][31:0]  req_portb;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_outport;
    logic [1:0][2:0]   rsp_flags;
    logic [3:0]        alu_aluop;
    logic [31:0]       alu_porta;
    logic [31:0]       alu_portb;
    logic [31:0]       alu_outport;
    logic [2:0]        alu_flags;

    int checks   = 0;
    int failures = 0;
    vec_t q0[$];
    vec_t q1[$];

    alu_share_arbiter #(.NREQ(2)) dut (
        .CLK         (clk),
        .nRST        (nRST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_aluop   (req_aluop),
        .req_porta   (req_porta),
        .req_portb   (req_portb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_outport (rsp_outport),
        .rsp_flags   (rsp_flags),
        .alu_aluop   (alu_aluop),
        .alu_porta   (alu_porta),
        .alu_portb   (alu_portb),
        .alu_outport (alu_outport),
        .alu_flags   (alu_flags)
    );

    // Behavioural ALU; flags = {negative, zero, overflow}.
    logic [31:0] alu_res;
    logic        alu_ovf;
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_aluop)
            ALU_SLL:  alu_res = alu_porta << alu_portb[4:0];
            ALU_SRL:  alu_res = alu_porta >> alu_portb[4:0];
            ALU_ADD: begin
                alu_res = alu_porta + alu_portb;
                alu_ovf = (alu_porta[31] == alu_portb[31]) && (alu_res[31] != alu_porta[31]);
            end
            ALU_SUB: begin
                alu_res = alu_porta - alu_portb;
                alu_ovf = (alu_porta[31] != alu_portb[31]) && (alu_res[31] != alu_porta[31]);
            end
            ALU_AND:  alu_res = alu_porta & alu_portb;
            ALU_OR:   alu_res = alu_porta | alu_portb;
            ALU_XOR:  alu_res = alu_porta ^ alu_portb;
            ALU_NOR:  alu_res = ~(alu_porta | alu_portb);
            ALU_SLT:  alu_res = {31'b0, $signed(alu_porta) < $signed(alu_portb)};
            ALU_SLTU: alu_res = {31'b0, alu_porta < alu_portb};
            default:  alu_res = '0;
        endcase
    end
    assign alu_outport = alu_res;
    assign alu_flags   = {alu_res[31], alu_res == 32'd0, alu_ovf};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic [2:0] fl);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl;
        return v;
    endfunction

    // One cycle of stimulus: drive at negedge, check the grant 1ns later and
    // record the expected response for each requester that should win.
    task automatic step(input logic [1:0] v, input logic [1:0] rr, input vec_t o0, input vec_t o1,
                        input logic [1:0] exp_rdy, input string tag);
        @(negedge clk);
        req_valid    = v;
        rsp_ready    = rr;
        req_aluop[0] = o0.op; req_porta[0] = o0.a; req_portb[0] = o0.b;
        req_aluop[1] = o1.op; req_porta[1] = o1.a; req_portb[1] = o1.b;
        #1;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy[0]) q0.push_back(o0);
        if (exp_rdy[1]) q1.push_back(o1);
        $display("cycle %s: valid=%b rsp_ready=%b req_ready=%b", tag, v, rr, req_ready);
    endtask

    // Monitor: a response is consumed when rsp_valid & rsp_ready at the next edge.
    always @(negedge clk) begin
        #2;
        if (nRST) begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    vec_t e;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        chk($sformatf("spurious_rsp%0d", i), 64'(1), 64'(0));
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rsp%0d_data", i), 64'({rsp_flags[i], rsp_outport[i]}),
                            64'({e.fl, e.res}));
                        $display("rsp slot%0d outport=%h flags=%b", i, rsp_outport[i], rsp_flags[i]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t va, vb, vc, vd, ve, vf, vg, vh, vu, idle;
        va   = mk(ALU_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 3'b101);
        vb   = mk(ALU_SUB, 32'd5,         32'd5,         32'h0,         3'b010);
        vc   = mk(ALU_ADD, 32'd3,         32'd4,         32'd7,         3'b000);
        vd   = mk(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b100);
        ve   = mk(ALU_OR,  32'h0,         32'h0,         32'h0,         3'b010);
        vf   = mk(ALU_XOR, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 3'b100);
        vg   = mk(ALU_SUB, 32'h0,         32'h1,         32'hFFFF_FFFF, 3'b100);
        vh   = mk(ALU_SLT, 32'hFFFF_FFFF, 32'd2,         32'd1,         3'b000);
        vu   = mk(4'hF,    32'd123,       32'd456,       32'h0,         3'b010);
        idle = '0;

        // Reset with both requesters presenting work.
        nRST = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_aluop[0] = va.op; req_porta[0] = va.a; req_portb[0] = va.b;
        req_aluop[1] = vb.op; req_porta[1] = vb.a; req_portb[1] = vb.b;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_alu_aluop", 64'(alu_aluop), 64'(0));
        chk("reset_alu_porta", 64'(alu_porta), 64'(0));
        chk("reset_alu_portb", 64'(alu_portb), 64'(0));
        req_valid = 2'b00;
        nRST = 1'b1;

        // Contention: grants alternate 0,1,0,1,0,1; losers change operands freely.
        step(2'b11, 2'b11, va, vb, 2'b01, "c1");
        chk("c1_alu_aluop", 64'(alu_aluop), 64'(ALU_ADD));
        chk("c1_alu_porta", 64'(alu_porta), 64'h7FFF_FFFF);
        chk("c1_alu_portb", 64'(alu_portb), 64'h1);
        step(2'b11, 2'b11, vc, vb, 2'b10, "c2");
        chk("c2_latency_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("c2_latency_outport0", 64'(rsp_outport[0]), 64'h8000_0000);
        step(2'b11, 2'b11, vc, vd, 2'b01, "c3");
        step(2'b11, 2'b11, ve, vd, 2'b10, "c4");
        step(2'b11, 2'b11, ve, vf, 2'b01, "c5");
        step(2'b11, 2'b11, vg, vf, 2'b10, "c6");

        // Backpressure: slot0 full and not draining, only req1 is granted.
        step(2'b01, 2'b11, vg, idle, 2'b01, "c7");
        step(2'b11, 2'b10, vh, vc, 2'b10, "c8");
        chk("c8_hold_outport0", 64'(rsp_outport[0]), 64'hFFFF_FFFF);
        step(2'b11, 2'b10, vh, vu, 2'b10, "c9");
        chk("c9_undef_op_passthru", 64'(alu_aluop), 64'hF);
        chk("c9_hold_slot0", 64'({rsp_valid[0], rsp_flags[0], rsp_outport[0]}),
            64'({1'b1, 3'b100, 32'hFFFF_FFFF}));
        step(2'b11, 2'b10, vh, vb, 2'b10, "c10");
        chk("c10_hold_outport0", 64'(rsp_outport[0]), 64'hFFFF_FFFF);

        // Drain and refill slot0 on the same edge.
        step(2'b01, 2'b11, vh, idle, 2'b01, "c11");
        step(2'b10, 2'b00, idle, vc, 2'b10, "c12");
        chk("c12_refill_valid0", 64'(rsp_valid[0]), 64'(1));
        chk("c12_refill_outport0", 64'({rsp_flags[0], rsp_outport[0]}), 64'({3'b000, 32'd1}));
        step(2'b00, 2'b00, idle, idle, 2'b00, "c13");
        chk("c13_both_full", 64'(rsp_valid), 64'(2'b11));
        chk("c13_idle_alu", 64'({alu_aluop, alu_porta, alu_portb}), 64'(0));

        // Mid-stream reset between clock edges: slots clear immediately.
        #2;
        req_valid = 2'b11;
        nRST = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_outport", 64'({rsp_outport[1], rsp_outport[0]}), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        q0.delete();
        q1.delete();
        req_valid = 2'b00;
        @(negedge clk);
        nRST = 1'b1;

        // First grant after release goes to req0, then a single-requester stream.
        step(2'b11, 2'b11, vc, vd, 2'b01, "c14");
        step(2'b10, 2'b11, idle, vd, 2'b10, "c15");
        step(2'b01, 2'b11, va, idle, 2'b01, "c16");
        step(2'b01, 2'b11, vb, idle, 2'b01, "c17");
        step(2'b00, 2'b11, idle, idle, 2'b00, "c18");

        // Bounded wait for the monitor to consume all outstanding responses.
        for (int n = 0; n < 10 && (q0.size() + q1.size()) != 0; n++) begin
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        #3;
        chk("all_responses_seen", 64'(q0.size() + q1.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
